// File: rtl/jt12_sh6_wrsched.sv
// Write scheduler for the 6-slot recirculating channel ring: queues CPU writes and strobes load/din when the target slot enters stage 1.
// Optional build macro JT12_SHSCHED_COLLAPSE_EN folds repeated writes to a queued channel into the existing entry.
module jt12_sh6_wrsched #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  output logic             load,
  output logic [WIDTH-1:0] din,
  output logic [2:0]       slot,
  output logic             zero,
  output logic             busy,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]       q_ch   [DEPTH];
  logic [WIDTH-1:0] q_data [DEPTH];
  logic [AW:0]      wptr, rptr, occ, occ_nxt;
  logic [AW-1:0]    head;
  logic             accept, bad_ch, push, pop, hit;
  logic [AW-1:0]    hit_idx;

  assign head   = rptr[AW-1:0];
  assign occ    = wptr - rptr;
  assign busy   = (wptr != rptr);
  assign zero   = (slot == 3'd0);
  // rst gates load so the ring never sees a stale strobe in the reset cycle
  assign load   = !rst && busy && (q_ch[head] == slot);
  assign din    = load ? q_data[head] : '0;
  assign pop    = load;
  assign accept = wr_valid && wr_ready;
  assign bad_ch = (wr_ch > 3'd5);

`ifdef JT12_SHSCHED_COLLAPSE_EN
  // Look for a queued entry of the same channel; the head is excluded only when it leaves this cycle.
  logic [AW-1:0] idx;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < occ && !(i == 0 && pop) && q_ch[idx] == wr_ch) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_idx = '0;
`endif

  assign push    = accept && !bad_ch && !hit;
  assign occ_nxt = occ + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= 3'd0;
      wptr     <= '0;
      rptr     <= '0;
      wr_ready <= 1'b1;
      err      <= 1'b0;
    end else begin
      slot     <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      err      <= accept && bad_ch;
      wr_ready <= (occ_nxt != (AW+1)'(DEPTH));
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while the pointers say they are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) begin
        q_ch[wptr[AW-1:0]]   <= wr_ch;
        q_data[wptr[AW-1:0]] <= wr_data;
      end
      if (accept && !bad_ch && hit)
        q_data[hit_idx] <= wr_data;
    end
  end

endmodule
